// File: rtl/axi_slave_mem1.sv
// axi_slave_mem1: AXI4 memory responder sitting on the master port of the
// request mux. Word-addressed internal RAM, one outstanding write burst and
// one outstanding read burst, B/R responses echo the request ID.
//
// Write FSM
//   state  | meaning
//   W_IDLE | awready offered, waiting for an AW handshake
//   W_DATA | wready high, consuming beats until the counted final beat
//   W_RESP | bvalid high with the latched ID, waiting for bready
//
// Read FSM
//   state  | meaning
//   R_IDLE | arready offered, waiting for an AR handshake
//   R_DATA | rvalid high, one beat per R handshake until rlast is taken
module axi_slave_mem1 #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [MASK_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int ALIGN = $clog2(MASK_WIDTH);
    localparam int IDXW  = $clog2(MEM_DEPTH);

    localparam logic [2:0]      SIZE_OK     = 3'(ALIGN);
    localparam logic [1:0]      BURST_INCR  = 2'b01;
    localparam logic [1:0]      RESP_OKAY   = 2'b00;
    localparam logic [1:0]      RESP_SLVERR = 2'b10;
    localparam logic [IDXW-1:0] IDX_ONE     = IDXW'(1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_e        w_state;
    logic [IDXW-1:0] w_idx;
    logic [7:0]      w_remaining;
    logic            w_bad;
    logic            w_err;

    r_state_e        r_state;
    logic [IDXW-1:0] r_idx;
    logic [7:0]      r_remaining;
    logic            r_bad;

    logic [IDXW-1:0] aw_idx;
    logic [IDXW-1:0] ar_idx;
    logic            aw_bad;
    logic            ar_bad;
    logic            w_final;
    logic            wlast_bad;
    logic            mem_we;

    // Only the word-index field of each address matters; the rest aliases.
    logic            unused_addr_bits;

    assign aw_idx    = awaddr[ALIGN +: IDXW];
    assign ar_idx    = araddr[ALIGN +: IDXW];
    assign aw_bad    = (awsize != SIZE_OK) || (awburst != BURST_INCR);
    assign ar_bad    = (arsize != SIZE_OK) || (arburst != BURST_INCR);
    assign w_final   = (w_remaining == 8'd0);
    assign wlast_bad = (wlast != w_final);
    assign mem_we    = (w_state == W_DATA) && wvalid && !w_bad;

    assign unused_addr_bits = ^{awaddr, araddr};

    // Write path: AW acceptance, beat counting, wlast checking and B response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state     <= W_IDLE;
            awready     <= 1'b0;
            wready      <= 1'b0;
            bvalid      <= 1'b0;
            bid         <= '0;
            bresp       <= RESP_OKAY;
            w_idx       <= '0;
            w_remaining <= '0;
            w_bad       <= 1'b0;
            w_err       <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (awvalid && awready) begin
                        awready     <= 1'b0;
                        wready      <= 1'b1;
                        bid         <= awid;
                        w_idx       <= aw_idx;
                        w_remaining <= awlen;
                        w_bad       <= aw_bad;
                        w_err       <= 1'b0;
                        w_state     <= W_DATA;
                    end else begin
                        // First edge after reset release opens the port.
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (wvalid) begin
                        w_idx <= w_idx + IDX_ONE;
                        if (w_final) begin
                            // The beat count ends the burst; wlast only grades it.
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (w_bad || w_err || wlast_bad) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            w_remaining <= w_remaining - 8'd1;
                            if (wlast_bad) begin
                                w_err <= 1'b1;
                            end
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // RAM byte-lane writes; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < MASK_WIDTH; k++) begin
                if (wstrb[k]) begin
                    mem[w_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Read path: AR acceptance and registered R beats; a same-cycle write sees old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= R_IDLE;
            arready     <= 1'b0;
            rvalid      <= 1'b0;
            rdata       <= '0;
            rid         <= '0;
            rresp       <= RESP_OKAY;
            rlast       <= 1'b0;
            r_idx       <= '0;
            r_remaining <= '0;
            r_bad       <= 1'b0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (arvalid && arready) begin
                        arready     <= 1'b0;
                        rvalid      <= 1'b1;
                        rid         <= arid;
                        rresp       <= ar_bad ? RESP_SLVERR : RESP_OKAY;
                        rlast       <= (arlen == 8'd0);
                        rdata       <= ar_bad ? '0 : mem[ar_idx];
                        r_idx       <= ar_idx + IDX_ONE;
                        r_remaining <= arlen;
                        r_bad       <= ar_bad;
                        r_state     <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    // Without rready every R output simply holds.
                    if (rready) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rdata       <= r_bad ? '0 : mem[r_idx];
                            r_idx       <= r_idx + IDX_ONE;
                            r_remaining <= r_remaining - 8'd1;
                            rlast       <= (r_remaining == 8'd1);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule
